// File: rtl/chime_pkg.sv
// Shared types and constants for the keylock chime sequencer: note half-periods
// for a 12 MHz clock, the ROM entry layout, FSM states and sequence start addresses.
package chime_pkg;

  localparam int ENTRY_HP_W = 32;
  localparam int ADDR_W     = 3;

  localparam logic [ADDR_W-1:0] SEQ_OK  = 3'd0;
  localparam logic [ADDR_W-1:0] SEQ_ERR = 3'd3;

  // Half-periods in 12 MHz clock cycles; zero marks a rest.
  localparam logic [ENTRY_HP_W-1:0] HP_C5   = 32'd11466;
  localparam logic [ENTRY_HP_W-1:0] HP_E5   = 32'd9101;
  localparam logic [ENTRY_HP_W-1:0] HP_G5   = 32'd7653;
  localparam logic [ENTRY_HP_W-1:0] HP_A3   = 32'd27273;
  localparam logic [ENTRY_HP_W-1:0] HP_REST = 32'd0;

  typedef struct packed {
    logic [ENTRY_HP_W-1:0] hp;
    logic [7:0]            units;
    logic                  last;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  function automatic entry_t mk_entry(input logic [ENTRY_HP_W-1:0] hp,
                                      input logic [7:0] units,
                                      input logic last);
    entry_t e;
    e.hp    = hp;
    e.units = units;
    e.last  = last;
    return e;
  endfunction

endpackage

// File: rtl/chime_rom.sv
// Combinational note ROM holding the accepted chime and the rejected buzz.
// Unused addresses return a short terminating rest so a stray address still ends cleanly.
module chime_rom
  import chime_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output entry_t            entry
);

  always_comb begin
    entry = mk_entry(HP_REST, 8'd1, 1'b1);
    case (addr)
      3'd0: entry = mk_entry(HP_C5,   8'd15, 1'b0);
      3'd1: entry = mk_entry(HP_E5,   8'd15, 1'b0);
      3'd2: entry = mk_entry(HP_G5,   8'd30, 1'b1);
      3'd3: entry = mk_entry(HP_A3,   8'd40, 1'b0);
      3'd4: entry = mk_entry(HP_REST, 8'd10, 1'b0);
      3'd5: entry = mk_entry(HP_A3,   8'd40, 1'b1);
      default: entry = mk_entry(HP_REST, 8'd1, 1'b1);
    endcase
  end

endmodule

// File: rtl/chime_sequencer.sv
// Steps through the note ROM on a trigger, presenting half-period / tone enable
// to the downstream square-wave generator; play_err always preempts.
module chime_sequencer
  import chime_pkg::*;
#(
  parameter int HP_W        = 32,
  parameter int UNIT_CYCLES = 120000
) (
  input  logic            hwclk,
  input  logic            rst,
  input  logic            play_ok,
  input  logic            play_err,
  output logic            busy,
  output logic            tone_en,
  output logic [HP_W-1:0] halfperiod,
  output logic            note_start,
  output logic            done
);

  localparam int CNT_W = $clog2(255 * UNIT_CYCLES);

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                last_reg;
  logic [HP_W-1:0]     hp_reg;
  logic                tone_en_reg;
  logic                note_start_reg;
  logic                done_reg;
  entry_t              rom_entry;
  logic [CNT_W-1:0]    load_val;

  chime_rom u_rom (
    .addr  (addr_reg),
    .entry (rom_entry)
  );

  // Counter runs units*UNIT_CYCLES-1 down to 0, giving exactly units*UNIT_CYCLES PLAY cycles.
  assign load_val = CNT_W'(rom_entry.units) * CNT_W'(UNIT_CYCLES) - CNT_W'(1);

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      cnt_reg        <= '0;
      last_reg       <= 1'b0;
      hp_reg         <= '0;
      tone_en_reg    <= 1'b0;
      note_start_reg <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      note_start_reg <= 1'b0;
      done_reg       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (play_err) begin
            addr_reg  <= SEQ_ERR;
            state_reg <= LOAD;
          end else if (play_ok) begin
            addr_reg  <= SEQ_OK;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (play_err) begin
            // Restart: the entry being loaded is discarded, outputs keep the old note.
            addr_reg <= SEQ_ERR;
          end else begin
            hp_reg         <= HP_W'(rom_entry.hp);
            tone_en_reg    <= (rom_entry.hp != '0);
            note_start_reg <= 1'b1;
            last_reg       <= rom_entry.last;
            cnt_reg        <= load_val;
            state_reg      <= PLAY;
          end
        end
        PLAY: begin
          if (play_err) begin
            addr_reg  <= SEQ_ERR;
            state_reg <= LOAD;
          end else if (cnt_reg == '0) begin
            if (last_reg) begin
              hp_reg      <= '0;
              tone_en_reg <= 1'b0;
              done_reg    <= 1'b1;
              state_reg   <= IDLE;
            end else begin
              addr_reg  <= addr_reg + 1'b1;
              state_reg <= LOAD;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign tone_en    = tone_en_reg;
  assign halfperiod = hp_reg;
  assign note_start = note_start_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_chime_sequencer.sv
// Randomized scoreboard bench for chime_sequencer: a sequence-level model predicts
// note_start/done events, a monitor pops and checks them and the held note outputs.
module tb_chime_sequencer;

  localparam int U    = 4;
  localparam int HP_W = 32;

  logic            hwclk = 1'b0;
  logic            rst = 1'b1;
  logic            play_ok = 1'b0;
  logic            play_err = 1'b0;
  logic            busy;
  logic            tone_en;
  logic [HP_W-1:0] halfperiod;
  logic            note_start;
  logic            done;

  chime_sequencer #(.HP_W(HP_W), .UNIT_CYCLES(U)) dut (
    .hwclk      (hwclk),
    .rst        (rst),
    .play_ok    (play_ok),
    .play_err   (play_err),
    .busy       (busy),
    .tone_en    (tone_en),
    .halfperiod (halfperiod),
    .note_start (note_start),
    .done       (done)
  );

  always #5 hwclk = ~hwclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Melody table as written in the requirements: half-period, duration units, last flag.
  int rom_hp[6]    = '{11466, 9101, 7653, 27273, 0, 27273};
  int rom_units[6] = '{15, 15, 30, 40, 10, 40};
  bit rom_last[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    bit is_done;
    int cyc;
    int hp;
    int blen;
  } ev_t;

  ev_t evq[$];
  int  model_done = -1;
  int  busy_start = 0;

  initial forever begin
    @(posedge hwclk);
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // A sequence whose first LOAD occupies cycle m; any pending events at or after m are aborted.
  function automatic void model_start(input int m, input int base);
    int   l;
    int   a;
    ev_t  e;
    if (m > model_done) busy_start = m;
    else while (evq.size() > 0 && evq[$].cyc >= m) void'(evq.pop_back());
    l = m;
    a = base;
    for (int k = 0; k < 6; k++) begin
      e.is_done = 1'b0; e.cyc = l + 1; e.hp = rom_hp[a]; e.blen = 0;
      evq.push_back(e);
      l = l + 1 + rom_units[a] * U;
      if (rom_last[a]) begin
        e.is_done = 1'b1; e.cyc = l; e.hp = 0; e.blen = l - busy_start;
        evq.push_back(e);
        model_done = l;
        break;
      end
      a++;
    end
  endfunction

  task automatic trigger(input bit ok, input bit err, output int m);
    @(posedge hwclk);
    #1;
    m = cyc + 1;
    if (err) model_start(m, 3);
    else if (ok && m > model_done) model_start(m, 0);
    play_ok  = ok;
    play_err = err;
    $display("cycle %0d: trigger play_ok=%0d play_err=%0d", cyc, ok, err);
    @(posedge hwclk);
    #1;
    play_ok  = 1'b0;
    play_err = 1'b0;
  endtask

  task automatic wait_until(input int target);
    int guard = 0;
    while (cyc < target && guard < 2000) begin
      @(posedge hwclk);
      #1;
      guard++;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((evq.size() != 0 || cyc <= model_done) && guard < 2000) begin
      @(posedge hwclk);
      #1;
      guard++;
    end
    if (guard >= 2000) chk("idle_timeout_pending_events", evq.size(), 0);
    repeat ($urandom_range(1, 6)) @(posedge hwclk);
    #1;
  endtask

  // Monitor: pops one expected event per note_start/done pulse and tracks the held note.
  initial begin
    ev_t e;
    int  cur_hp;
    bit  prev_busy;
    int  bstart;
    cur_hp = 0; prev_busy = 1'b0; bstart = 0;
    forever begin
      @(negedge hwclk);
      if (rst) begin
        cur_hp    = 0;
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) bstart = cyc;
        prev_busy = busy;
        if (note_start || done) begin
          if (evq.size() == 0) begin
            chk("spurious_pulse", int'({note_start, done}), 0);
          end else begin
            e = evq.pop_front();
            chk("event_is_done", int'(done), int'(e.is_done));
            chk("event_cycle", cyc, e.cyc);
            if (e.is_done) begin
              chk("busy_len", cyc - bstart, e.blen);
              cur_hp = 0;
              $display("cycle %0d: done, busy for %0d cycles", cyc, cyc - bstart);
            end else begin
              cur_hp = e.hp;
              $display("cycle %0d: note_start halfperiod=%0d tone_en=%0d", cyc, halfperiod, tone_en);
            end
          end
        end
        chk("halfperiod", int'(halfperiod), cur_hp);
        chk("tone_en", int'(tone_en), int'(cur_hp != 0));
      end
    end
  end

  initial begin
    int m;
    int kind;
    repeat (3) @(posedge hwclk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_tone_en", int'(tone_en), 0);
    chk("reset_halfperiod", int'(halfperiod), 0);
    chk("reset_note_start", int'(note_start), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    repeat (2) @(posedge hwclk);

    // Accepted chime, rejected buzz, simultaneous triggers
    trigger(1'b1, 1'b0, m);
    wait_idle();
    trigger(1'b0, 1'b1, m);
    wait_idle();
    trigger(1'b1, 1'b1, m);
    wait_idle();

    // Preemption of the chime by the buzz, then an ignored play_ok mid-buzz
    trigger(1'b1, 1'b0, m);
    wait_until(m + 99 + $urandom_range(0, 20));
    trigger(1'b0, 1'b1, m);
    wait_until(cyc + $urandom_range(50, 150));
    trigger(1'b1, 1'b0, m);
    wait_idle();

    // Random triggers with random second triggers that may land mid-sequence
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      trigger(kind != 1, kind != 0, m);
      if ($urandom_range(0, 1) == 1) begin
        wait_until(cyc + $urandom_range(0, 400));
        kind = $urandom_range(0, 2);
        trigger(kind != 1, kind != 0, m);
      end
      wait_idle();
    end

    // Asynchronous reset during G5, then a full replay of the chime
    trigger(1'b1, 1'b0, m);
    wait_until(m + 123 + 40);
    @(posedge hwclk);
    #2;
    chk("pre_reset_halfperiod", int'(halfperiod), 7653);
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_tone_en", int'(tone_en), 0);
    chk("async_reset_halfperiod", int'(halfperiod), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    evq.delete();
    model_done = -1;
    repeat (2) @(posedge hwclk);
    #1;
    rst = 1'b0;
    $display("cycle %0d: reset released", cyc);
    repeat (3) @(posedge hwclk);
    trigger(1'b1, 1'b0, m);
    wait_idle();

    chk("final_queue_empty", evq.size(), 0);
    chk("final_busy", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
